// File: rtl/time_display.sv
// Two-digit 7-segment driver for the stopwatch: serial binary-to-BCD conversion, digit scan, pause blink.
// Digits update atomically 6 edges after a time change; seg_o follows one edge later.
module time_display #(
  parameter int SCAN_DIV  = 4,
  parameter int BLINK_DIV = 50
) (
  input  logic       clk,
  input  logic       nRst_i,
  input  logic [4:0] time_i,
  input  logic [2:0] mode_i,
  output logic [6:0] seg_o,
  output logic [1:0] digit_sel_o,
  output logic       busy_o
);

  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic {WAIT, SHIFT} state_t;

  state_t      state;
  logic [4:0]  last_time;
  logic [4:0]  shreg;
  logic [7:0]  bcd;
  logic [2:0]  iter;
  logic [3:0]  tens;
  logic [3:0]  ones;

  logic [7:0]  bcd_adj;
  logic [7:0]  bcd_nxt;
  logic [4:0]  sh_nxt;

  // One double-dabble step: correct nibbles >= 5, then shift the whole scratch left.
  always_comb begin
    bcd_adj = bcd;
    if (bcd[3:0] >= 4'd5) bcd_adj[3:0] = bcd[3:0] + 4'd3;
    if (bcd[7:4] >= 4'd5) bcd_adj[7:4] = bcd[7:4] + 4'd3;
    {bcd_nxt, sh_nxt} = {bcd_adj, shreg} << 1;
  end

  always_ff @(posedge clk or negedge nRst_i) begin
    if (!nRst_i) begin
      state     <= WAIT;
      last_time <= 5'd0;
      shreg     <= 5'd0;
      bcd       <= 8'd0;
      iter      <= 3'd0;
      tens      <= 4'd0;
      ones      <= 4'd0;
      busy_o    <= 1'b0;
    end else begin
      case (state)
        WAIT: begin
          if (time_i != last_time) begin
            last_time <= time_i;
            shreg     <= time_i;
            bcd       <= 8'd0;
            iter      <= 3'd0;
            busy_o    <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          bcd   <= bcd_nxt;
          shreg <= sh_nxt;
          iter  <= iter + 3'd1;
          // tens/ones only ever see the finished result
          if (iter == 3'd4) begin
            tens   <= bcd_nxt[7:4];
            ones   <= bcd_nxt[3:0];
            busy_o <= 1'b0;
            state  <= WAIT;
          end
        end
        default: state <= WAIT;
      endcase
    end
  end

  function automatic logic [6:0] encode(input logic [3:0] d);
    case (d)
      4'd0:    encode = 7'h3F;
      4'd1:    encode = 7'h06;
      4'd2:    encode = 7'h5B;
      4'd3:    encode = 7'h4F;
      4'd4:    encode = 7'h66;
      4'd5:    encode = 7'h6D;
      4'd6:    encode = 7'h7D;
      4'd7:    encode = 7'h07;
      4'd8:    encode = 7'h7F;
      4'd9:    encode = 7'h6F;
      default: encode = 7'h40;
    endcase
  endfunction

  logic [SW-1:0] scan_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink_on;

  logic          scan_wrap;
  logic          blink_wrap;
  logic          is_idle;
  logic          mode_ok;
  logic [1:0]    sel_nxt;
  logic          on_nxt;
  logic [3:0]    digit;
  logic [6:0]    seg_nxt;

  // seg_o is computed from the next select/phase so both registers change together.
  always_comb begin
    scan_wrap  = (scan_cnt == SW'(SCAN_DIV - 1));
    blink_wrap = (blink_cnt == BW'(BLINK_DIV - 1));
    is_idle    = (mode_i == 3'b001);
    mode_ok    = (mode_i == 3'b001) || (mode_i == 3'b010) || (mode_i == 3'b100);
    sel_nxt    = scan_wrap ? ~digit_sel_o : digit_sel_o;
    on_nxt     = is_idle ? (blink_wrap ? ~blink_on : blink_on) : 1'b1;
    digit      = sel_nxt[1] ? tens : ones;
    seg_nxt    = encode(digit);
    if (!mode_ok || !on_nxt || (sel_nxt[1] && tens == 4'd0)) seg_nxt = 7'h00;
  end

  always_ff @(posedge clk or negedge nRst_i) begin
    if (!nRst_i) begin
      scan_cnt    <= '0;
      blink_cnt   <= '0;
      blink_on    <= 1'b1;
      digit_sel_o <= 2'b01;
      seg_o       <= 7'h00;
    end else begin
      scan_cnt    <= scan_wrap ? '0 : scan_cnt + 1'b1;
      digit_sel_o <= sel_nxt;
      blink_on    <= on_nxt;
      seg_o       <= seg_nxt;
      if (is_idle) blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
      else         blink_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_time_display.sv
// Directed bench for time_display: conversion timing, back-to-back changes, blink, invalid mode, reset abort.
module tb_time_display;

  logic       clk;
  logic       nRst_i;
  logic [4:0] time_i;
  logic [2:0] mode_i;
  logic [6:0] seg_o;
  logic [1:0] digit_sel_o;
  logic       busy_o;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [2:0] M_IDLE = 3'b001;
  localparam logic [2:0] M_RUN  = 3'b100;

  time_display #(.SCAN_DIV(4), .BLINK_DIV(50)) dut (
    .clk         (clk),
    .nRst_i      (nRst_i),
    .time_i      (time_i),
    .mode_i      (mode_i),
    .seg_o       (seg_o),
    .digit_sel_o (digit_sel_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Collects the segment pattern seen in each scan slot over two full slots.
  task automatic get_digits(output logic [6:0] o_seg, output logic [6:0] t_seg);
    o_seg = 7'h7F;
    t_seg = 7'h7F;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (digit_sel_o == 2'b01) o_seg = seg_o;
      if (digit_sel_o == 2'b10) t_seg = seg_o;
    end
  endtask

  task automatic test_reset();
    logic [6:0] o, t;
    int busy_seen;
    nRst_i = 1'b0;
    time_i = 5'd0;
    mode_i = M_RUN;
    tick();
    tick();
    n_cmp++; if (seg_o !== 7'h00) begin n_fail++; $display("FAIL rst_seg got %h want 00", seg_o); end
    n_cmp++; if (digit_sel_o !== 2'b01) begin n_fail++; $display("FAIL rst_sel got %b want 01", digit_sel_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy_o); end
    nRst_i = 1'b1;
    tick();
    n_cmp++;
    if (seg_o !== 7'h3F || digit_sel_o !== 2'b01) begin
      n_fail++; $display("FAIL rel_first seg=%h sel=%b want 3F/01", seg_o, digit_sel_o);
    end
    busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy_o !== 1'b0) busy_seen++;
    end
    n_cmp++; if (busy_seen != 0) begin n_fail++; $display("FAIL rel_busy high %0d cycles want 0", busy_seen); end
    get_digits(o, t);
    n_cmp++; if (o !== 7'h3F) begin n_fail++; $display("FAIL rst_ones got %h want 3F", o); end
    n_cmp++; if (t !== 7'h00) begin n_fail++; $display("FAIL rst_tens got %h want 00", t); end
  endtask

  task automatic test_convert();
    logic [6:0] o, t, exp_seg;
    time_i = 5'd23;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if (busy_o !== (i < 5)) begin
        n_fail++; $display("FAIL conv_busy edge k+%0d got %b want %b", i, busy_o, (i < 5));
      end
      exp_seg = (digit_sel_o == 2'b01) ? 7'h3F : 7'h00;
      n_cmp++;
      if (seg_o !== exp_seg) begin
        n_fail++; $display("FAIL conv_partial edge k+%0d got %h want %h", i, seg_o, exp_seg);
      end
    end
    get_digits(o, t);
    n_cmp++; if (o !== 7'h4F) begin n_fail++; $display("FAIL conv23_ones got %h want 4F", o); end
    n_cmp++; if (t !== 7'h5B) begin n_fail++; $display("FAIL conv23_tens got %h want 5B", t); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] o, t, exp_seg;
    time_i = 5'd12;
    for (int i = 0; i < 8; i++) tick();
    time_i = 5'd23;
    tick();
    n_cmp++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL b2b_start got %b want 1", busy_o); end
    tick();
    time_i = 5'd31;
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL b2b_done1 got %b want 0", busy_o); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (busy_o !== 1'b1) begin n_fail++; $display("FAIL b2b_busy2 step %0d got %b want 1", i, busy_o); end
      exp_seg = (digit_sel_o == 2'b01) ? 7'h4F : 7'h5B;
      n_cmp++;
      if (seg_o !== exp_seg) begin n_fail++; $display("FAIL b2b_show23 step %0d got %h want %h", i, seg_o, exp_seg); end
    end
    tick();
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL b2b_done2 got %b want 0", busy_o); end
    get_digits(o, t);
    n_cmp++; if (o !== 7'h06) begin n_fail++; $display("FAIL b2b31_ones got %h want 06", o); end
    n_cmp++; if (t !== 7'h4F) begin n_fail++; $display("FAIL b2b31_tens got %h want 4F", t); end
  endtask

  task automatic test_blink();
    logic [6:0] o, t, exp_seg;
    logic [1:0] prev_sel;
    int toggles, bad;
    time_i = 5'd7;
    for (int i = 0; i < 8; i++) tick();
    get_digits(o, t);
    n_cmp++; if (o !== 7'h07) begin n_fail++; $display("FAIL blink_pre_ones got %h want 07", o); end
    n_cmp++; if (t !== 7'h00) begin n_fail++; $display("FAIL blink_pre_tens got %h want 00", t); end
    mode_i = M_IDLE;
    prev_sel = digit_sel_o;
    toggles = 0;
    bad = 0;
    for (int n = 1; n <= 160; n++) begin
      tick();
      if (digit_sel_o != prev_sel) toggles++;
      prev_sel = digit_sel_o;
      exp_seg = (digit_sel_o == 2'b01 && ((n / 50) % 2 == 0)) ? 7'h07 : 7'h00;
      if (seg_o !== exp_seg) begin
        bad++;
        if (bad <= 4) $display("FAIL blink_seg idle edge %0d got %h want %h", n, seg_o, exp_seg);
      end
    end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL blink_pattern %0d bad cycles want 0", bad); end
    n_cmp++; if (toggles != 40) begin n_fail++; $display("FAIL blink_scan toggles %0d want 40", toggles); end
    mode_i = M_RUN;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_seg = (digit_sel_o == 2'b01) ? 7'h07 : 7'h00;
      if (seg_o !== exp_seg) bad++;
    end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL blink_resume %0d bad cycles want 0", bad); end
  endtask

  task automatic test_invalid_mode();
    logic [1:0] prev_sel;
    int toggles, lit;
    mode_i = 3'b000;
    prev_sel = digit_sel_o;
    toggles = 0;
    lit = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 8) mode_i = 3'b011;
      if (digit_sel_o != prev_sel) toggles++;
      prev_sel = digit_sel_o;
      if (seg_o !== 7'h00) lit++;
    end
    n_cmp++; if (lit != 0) begin n_fail++; $display("FAIL bad_mode_seg lit %0d cycles want 0", lit); end
    n_cmp++; if (toggles != 4) begin n_fail++; $display("FAIL bad_mode_scan toggles %0d want 4", toggles); end
    mode_i = M_RUN;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [6:0] o, t;
    time_i = 5'd19;
    for (int i = 0; i < 3; i++) tick();
    nRst_i = 1'b0;
    #1;
    n_cmp++;
    if (seg_o !== 7'h00 || digit_sel_o !== 2'b01 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst seg=%h sel=%b busy=%b want 00/01/0", seg_o, digit_sel_o, busy_o);
    end
    @(negedge clk);
    nRst_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if (busy_o !== (i < 5)) begin n_fail++; $display("FAIL mid_busy edge %0d got %b want %b", i, busy_o, (i < 5)); end
      if (i == 0) begin
        n_cmp++;
        if (seg_o !== 7'h3F) begin n_fail++; $display("FAIL mid_abort seg got %h want 3F", seg_o); end
      end
    end
    get_digits(o, t);
    n_cmp++; if (o !== 7'h6F) begin n_fail++; $display("FAIL mid19_ones got %h want 6F", o); end
    n_cmp++; if (t !== 7'h06) begin n_fail++; $display("FAIL mid19_tens got %h want 06", t); end
  endtask

  initial begin
    nRst_i = 1'b0;
    time_i = 5'd0;
    mode_i = M_RUN;
    @(negedge clk);
    test_reset();
    test_convert();
    test_back_to_back();
    test_blink();
    test_invalid_mode();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
